// File: rtl/bram_test_pkg.sv
// Shared codes for the BRAM self-test: pattern selectors, LFSR constants, FSM states.
// Pure definitions, no timing or flow control of its own.
package bram_test_pkg;

    typedef enum logic [1:0] {
        PAT_WALK0 = 2'd0,
        PAT_ADDR  = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_NADDR = 2'd3
    } pat_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Right-shifting Galois step: the bit shifted out folds the mask back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/bram_pattern_gen.sv
// Test-pattern source: word is combinational from state; clear reseeds, step advances.
// No flow control; the caller steps it exactly once per word consumed.
module bram_pattern_gen
    import bram_test_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pat_e              sel,
    input  logic              clear,
    input  logic              step,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);

    localparam logic [DATA_W-1:0] WALK_SEED = ~DATA_W'(1);

    logic [DATA_W-1:0] walk_q;
    logic [31:0]       lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk_q <= WALK_SEED;
            lfsr_q <= LFSR_SEED;
        end else if (clear) begin
            walk_q <= WALK_SEED;
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            walk_q <= (walk_q << 1) | (walk_q >> (DATA_W - 1));
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        word = '0;
        case (sel)
            PAT_WALK0: word = walk_q;
            PAT_ADDR:  word = DATA_W'(addr);
            PAT_LFSR:  word = lfsr_q[DATA_W-1:0];
            PAT_NADDR: word = ~DATA_W'(addr);
            default:   word = '0;
        endcase
    end

endmodule

// File: rtl/bram_pattern_checker.sv
// BRAM self-test: writes DEPTH words, reads them back every PACE_DIV clocks and compares.
// Runs to completion once started; RAM read data is expected exactly RD_LAT cycles after address.
module bram_pattern_checker
    import bram_test_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 2048,
    parameter int ADDR_W   = 11,
    parameter int RD_LAT   = 1,
    parameter int PACE_DIV = 13_500_000,
    parameter int ERR_W    = 16
) (
    input  logic              clk_in,
    input  logic              btn_rst,
    input  logic              start,
    input  logic [1:0]        pat_sel,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wre,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int                PACE_W    = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(PACE_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_e             state_q;
    pat_e               pat_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [PACE_W-1:0]  pace_q;
    logic [DATA_W-1:0]  rd_q;
    logic [ERR_W-1:0]   err_q;
    logic [ADDR_W-1:0]  ferr_q;
    logic               done_q;

    logic [RD_LAT-1:0]  vld_q;
    logic [DATA_W-1:0]  pexp_q [RD_LAT];
    logic [ADDR_W-1:0]  padr_q [RD_LAT];

    logic               accept, issue, drain_last, cmp_vld, mism;
    logic               gen_clear, gen_step;
    logic [DATA_W-1:0]  gen_word;

    assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign issue     = (state_q == ST_READ) && (pace_q == PACE_LAST);
    assign cmp_vld   = vld_q[RD_LAT-1];
    assign mism      = cmp_vld && (ram_dout != pexp_q[RD_LAT-1]);
    assign gen_step  = (state_q == ST_WRITE) || issue;
    assign gen_clear = accept
                    || (state_q == ST_WRITE && addr_q == ADDR_LAST)
                    || (state_q == ST_DRAIN && drain_last && loop_en);

    // DRAIN can end once only the oldest stage is still occupied: it compares on this edge.
    always_comb begin
        drain_last = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (vld_q[i]) drain_last = 1'b0;
        end
    end

    bram_pattern_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_gen (
        .clk   (clk_in),
        .rst_n (btn_rst),
        .sel   (pat_q),
        .clear (gen_clear),
        .step  (gen_step),
        .addr  (addr_q),
        .word  (gen_word)
    );

    always_ff @(posedge clk_in or negedge btn_rst) begin
        if (!btn_rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pexp_q[i] <= '0;
                padr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= issue;
            pexp_q[0] <= gen_word;
            padr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                pexp_q[i] <= pexp_q[i-1];
                padr_q[i] <= padr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge btn_rst) begin
        if (!btn_rst) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_WALK0;
            addr_q  <= '0;
            pace_q  <= '0;
            rd_q    <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            if (cmp_vld) begin
                rd_q <= ram_dout;
                if (mism) begin
                    if (err_q == '0) ferr_q <= padr_q[RD_LAT-1];
                    if (err_q != '1) err_q <= err_q + ERR_W'(1);
                end
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_q <= ST_WRITE;
                        pat_q   <= pat_e'(pat_sel);
                        addr_q  <= '0;
                        err_q   <= '0;
                        ferr_q  <= '0;
                        done_q  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // Looping: done was raised for one cycle with the finished run's results.
                    if (done_q) begin
                        done_q <= 1'b0;
                        err_q  <= '0;
                        ferr_q <= '0;
                    end
                    if (addr_q == ADDR_LAST) begin
                        state_q <= ST_READ;
                        addr_q  <= '0;
                        pace_q  <= '0;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        pace_q <= '0;
                        if (addr_q == ADDR_LAST) begin
                            state_q <= ST_DRAIN;
                            addr_q  <= '0;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end else begin
                        pace_q <= pace_q + PACE_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        done_q  <= 1'b1;
                        state_q <= loop_en ? ST_WRITE : ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_ad         = addr_q;
    assign ram_wre        = (state_q == ST_WRITE);
    assign ram_din        = ram_wre ? gen_word : '0;
    assign rd_data        = rd_q;
    assign busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done           = done_q;
    assign pass           = done_q && (err_q == '0);
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;

endmodule
